toy_env_mmio_slave: RTL and testbench

- Memory-mapped environment slave on the core's external-memory port.
- Provides:
  - a simulation finish/status register and a character-output register;
  - software and timer-driven machine interrupts (intr_msip, intr_meip);
  - a bit-banged JTAG master whose pins drive the core's debug TAP.
- Single-cycle SRAM-style bus; sits beside the core in the top-level environment.

---
 rtl/toy_env_mmio_slave.sv | 214 +++++++++++++++++++++
 tb/tb_toy_env_mmio_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/toy_env_mmio_slave.sv
// Memory-mapped environment slave: sim finish/putc, msip/meip interrupts, countdown timer, bit-banged JTAG.
// Optional free-running cycle counter at 0x1C is enabled by defining TOY_ENV_CYCLE_CNT_EN.
module toy_env_mmio_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    intr_msip,
  output logic                    intr_meip,
  output logic                    jtag_clk,
  output logic                    jtag_rst_n,
  output logic                    jtag_tms,
  output logic                    jtag_tdi,
  input  logic                    jtag_tdo,
  output logic                    finish_vld,
  output logic [31:0]             finish_code,
  output logic                    putc_vld,
  output logic [7:0]              putc_data
);

  localparam logic [5:0] IDX_SIM_CTRL = 6'd0;
  localparam logic [5:0] IDX_PUTC     = 6'd1;
  localparam logic [5:0] IDX_MSIP     = 6'd2;
  localparam logic [5:0] IDX_MEIP     = 6'd3;
  localparam logic [5:0] IDX_TIMER    = 6'd4;
  localparam logic [5:0] IDX_JTAG     = 6'd5;
  localparam logic [5:0] IDX_TDO      = 6'd6;
  localparam logic [5:0] IDX_CYCLE    = 6'd7;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic                  wr_s, rd_s, timer_wr_s, expiry_s;
  logic [5:0]            idx_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s, rd_mux_s, cycle_s;
  logic                  unused_s;

  logic [31:0]           finish_code_q, finish_code_d;
  logic                  finish_vld_q, finish_vld_d;
  logic [7:0]            putc_data_q, putc_data_d;
  logic                  putc_vld_q, putc_vld_d;
  logic                  msip_q, msip_d;
  logic                  meip_q, meip_d;
  logic [31:0]           timer_q, timer_d;
  logic [3:0]            jtag_q, jtag_d;
  logic [1:0]            tdo_sync_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  assign wr_s       = en & wr_en;
  assign rd_s       = en & ~wr_en;
  assign idx_s      = addr[7:2];
  assign be_s       = wr_byte_en[3:0];
  assign wdata_s    = wr_data[31:0];
  assign timer_wr_s = wr_s & (idx_s == IDX_TIMER) & (|be_s);
  // A software write to TIMER pre-empts the natural 1->0 expiry in that cycle.
  assign expiry_s   = (timer_q == 32'd1) & ~timer_wr_s;
  assign unused_s   = ^{addr, wr_data, wr_byte_en};

`ifdef TOY_ENV_CYCLE_CNT_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
  assign cycle_s = cycle_q;
`else
  assign cycle_s = 32'd0;
`endif

  // Read-data multiplexer over the decoded word index.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      IDX_SIM_CTRL: rd_mux_s = finish_code_q;
      IDX_PUTC:     rd_mux_s = 32'd0;
      IDX_MSIP:     rd_mux_s = {31'd0, msip_q};
      IDX_MEIP:     rd_mux_s = {31'd0, meip_q};
      IDX_TIMER:    rd_mux_s = timer_q;
      IDX_JTAG:     rd_mux_s = {28'd0, jtag_q};
      IDX_TDO:      rd_mux_s = {31'd0, tdo_sync_q[1]};
      IDX_CYCLE:    rd_mux_s = cycle_s;
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Next-state for all registers: timer decrement, bus writes, expiry, read capture.
  always_comb begin
    finish_code_d = finish_code_q;
    finish_vld_d  = 1'b0;
    putc_data_d   = putc_data_q;
    putc_vld_d    = 1'b0;
    msip_d        = msip_q;
    meip_d        = meip_q;
    jtag_d        = jtag_q;
    rd_data_d     = rd_data_q;
    if (timer_q != 32'd0) begin
      timer_d = timer_q - 32'd1;
    end else begin
      timer_d = timer_q;
    end
    if (wr_s) begin
      case (idx_s)
        IDX_SIM_CTRL: begin
          if (|be_s) begin
            finish_code_d = merge_bytes(finish_code_q, wdata_s, be_s);
            finish_vld_d  = 1'b1;
          end else begin
            finish_vld_d  = 1'b0;
          end
        end
        IDX_PUTC: begin
          if (be_s[0]) begin
            putc_data_d = wdata_s[7:0];
            putc_vld_d  = 1'b1;
          end else begin
            putc_vld_d  = 1'b0;
          end
        end
        IDX_MSIP: msip_d = be_s[0] ? wdata_s[0] : msip_q;
        IDX_MEIP: meip_d = be_s[0] ? wdata_s[0] : meip_q;
        IDX_TIMER: begin
          if (|be_s) begin
            timer_d = merge_bytes(timer_q, wdata_s, be_s);
          end else begin
            timer_d = timer_d;
          end
        end
        IDX_JTAG: jtag_d = be_s[0] ? wdata_s[3:0] : jtag_q;
        default: ;
      endcase
    end else begin
      jtag_d = jtag_q;
    end
    // Expiry overrides a same-cycle software clear of MEIP.
    if (expiry_s) begin
      meip_d = 1'b1;
    end else begin
      meip_d = meip_d;
    end
    if (rd_s) begin
      rd_data_d       = {DATA_WIDTH{1'b0}};
      rd_data_d[31:0] = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish_code_q <= 32'd0;
      finish_vld_q  <= 1'b0;
      putc_data_q   <= 8'd0;
      putc_vld_q    <= 1'b0;
      msip_q        <= 1'b0;
      meip_q        <= 1'b0;
      timer_q       <= 32'd0;
      jtag_q        <= 4'd0;
      rd_data_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      finish_code_q <= finish_code_d;
      finish_vld_q  <= finish_vld_d;
      putc_data_q   <= putc_data_d;
      putc_vld_q    <= putc_vld_d;
      msip_q        <= msip_d;
      meip_q        <= meip_d;
      timer_q       <= timer_d;
      jtag_q        <= jtag_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Two-flop synchronizer for the asynchronous TDO pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo_sync_q <= 2'b00;
    end else begin
      tdo_sync_q <= {tdo_sync_q[0], jtag_tdo};
    end
  end

  assign rd_data     = rd_data_q;
  assign intr_msip   = msip_q;
  assign intr_meip   = meip_q;
  assign jtag_clk    = jtag_q[0];
  assign jtag_tms    = jtag_q[1];
  assign jtag_tdi    = jtag_q[2];
  assign jtag_rst_n  = jtag_q[3];
  assign finish_vld  = finish_vld_q;
  assign finish_code = finish_code_q;
  assign putc_vld    = putc_vld_q;
  assign putc_data   = putc_data_q;

endmodule

// File: tb/tb_toy_env_mmio_slave.sv
// Directed self-checking bench for toy_env_mmio_slave with hand-computed expectations.
module tb_toy_env_mmio_slave;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  wr_byte_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        intr_msip, intr_meip;
  logic        jtag_clk, jtag_rst_n, jtag_tms, jtag_tdi, jtag_tdo;
  logic        finish_vld, putc_vld;
  logic [31:0] finish_code;
  logic [7:0]  putc_data;

  int checks_cnt;
  int fail_cnt;

  toy_env_mmio_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr), .wr_en(wr_en),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_data(rd_data),
    .intr_msip(intr_msip), .intr_meip(intr_meip),
    .jtag_clk(jtag_clk), .jtag_rst_n(jtag_rst_n), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .finish_vld(finish_vld), .finish_code(finish_code),
    .putc_vld(putc_vld), .putc_data(putc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    en = 1'b1; wr_en = 1'b1; addr = a; wr_data = d; wr_byte_en = be;
    @(posedge clk); #1;
    en = 1'b0; wr_en = 1'b0; wr_byte_en = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr_en = 1'b0; addr = a;
    @(posedge clk); #1;
    en = 1'b0;
    d = rd_data;
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] c0;
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; addr = 32'h0;
    wr_byte_en = 4'h0; wr_data = 32'h0; jtag_tdo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_irqs", {30'd0, intr_msip, intr_meip}, 32'h0);
    check_eq("rst_jtag", {28'd0, jtag_rst_n, jtag_tdi, jtag_tms, jtag_clk}, 32'h0);
    check_eq("rst_pulses", {30'd0, finish_vld, putc_vld}, 32'h0);
    check_eq("rst_finish_code", finish_code, 32'h0);
    check_eq("rst_putc_data", {24'd0, putc_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset read sweep of every offset
    for (int i = 0; i < 8; i++) begin
      bus_read(32'(i * 4), rv);
`ifdef TOY_ENV_CYCLE_CNT_EN
      if (i != 7) check_eq($sformatf("sweep_0x%02h", i * 4), rv, 32'h0);
`else
      check_eq($sformatf("sweep_0x%02h", i * 4), rv, 32'h0);
`endif
    end

    // PUTC
    bus_write(32'h04, 32'h0000_0041, 4'h1);
    check_eq("putc_vld_hi", {31'd0, putc_vld}, 32'h1);
    check_eq("putc_data", {24'd0, putc_data}, 32'h41);
    @(posedge clk); #1;
    check_eq("putc_vld_lo", {31'd0, putc_vld}, 32'h0);
    bus_read(32'h04, rv);
    check_eq("putc_read0", rv, 32'h0);

    // SIM_CTRL
    bus_write(32'h00, 32'hCAFE_0001, 4'hF);
    check_eq("fin_vld_hi", {31'd0, finish_vld}, 32'h1);
    check_eq("fin_code", finish_code, 32'hCAFE_0001);
    @(posedge clk); #1;
    check_eq("fin_vld_lo", {31'd0, finish_vld}, 32'h0);
    bus_read(32'h00, rv);
    check_eq("fin_readback", rv, 32'hCAFE_0001);

    // Back-to-back PUTC writes
    @(negedge clk);
    en = 1'b1; wr_en = 1'b1; addr = 32'h04; wr_data = 32'h61; wr_byte_en = 4'h1;
    @(posedge clk); #1;
    check_eq("b2b_vld0", {31'd0, putc_vld}, 32'h1);
    check_eq("b2b_data0", {24'd0, putc_data}, 32'h61);
    @(negedge clk);
    wr_data = 32'h62;
    @(posedge clk); #1;
    en = 1'b0; wr_en = 1'b0; wr_byte_en = 4'h0;
    check_eq("b2b_vld1", {31'd0, putc_vld}, 32'h1);
    check_eq("b2b_data1", {24'd0, putc_data}, 32'h62);
    @(posedge clk); #1;
    check_eq("b2b_vld_end", {31'd0, putc_vld}, 32'h0);

    // Partial byte-enable write and zero-enable write
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h00, 32'h1234_5678, 4'h3);
    bus_read(32'h00, rv);
    check_eq("partial_wr", rv, 32'hFFFF_5678);
    bus_write(32'h00, 32'h0000_0000, 4'h0);
    check_eq("be0_no_pulse", {31'd0, finish_vld}, 32'h0);
    check_eq("be0_code_kept", finish_code, 32'hFFFF_5678);

    // MSIP
    bus_write(32'h08, 32'h1, 4'hF);
    check_eq("msip_set", {31'd0, intr_msip}, 32'h1);
    bus_write(32'h08, 32'h0, 4'hF);
    check_eq("msip_clr", {31'd0, intr_msip}, 32'h0);

    // Timer expiry 5 cycles after the write edge
    bus_write(32'h10, 32'd5, 4'hF);
    check_eq("tmr_meip_t0", {31'd0, intr_meip}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("tmr_meip_t%0d", k), {31'd0, intr_meip}, 32'h0);
    end
    @(posedge clk); #1;
    check_eq("tmr_meip_t5", {31'd0, intr_meip}, 32'h1);
    bus_read(32'h10, rv);
    check_eq("tmr_zero", rv, 32'h0);
    bus_write(32'h0C, 32'h0, 4'hF);
    check_eq("meip_clr", {31'd0, intr_meip}, 32'h0);

    // Clear on the expiry cycle: expiry wins
    bus_write(32'h10, 32'd3, 4'hF);
    @(posedge clk);
    @(posedge clk);
    bus_write(32'h0C, 32'h0, 4'hF);
    check_eq("expiry_wins", {31'd0, intr_meip}, 32'h1);
    bus_write(32'h0C, 32'h0, 4'hF);
    check_eq("late_clear", {31'd0, intr_meip}, 32'h0);

    // Write overrides decrement, then write 0 stops timer
    bus_write(32'h10, 32'd100, 4'hF);
    bus_write(32'h10, 32'd7, 4'hF);
    bus_read(32'h10, rv);
    check_eq("tmr_wr_wins", rv, 32'd7);
    bus_write(32'h10, 32'd0, 4'hF);
    bus_read(32'h10, rv);
    check_eq("tmr_stopped", rv, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("tmr_no_irq", {31'd0, intr_meip}, 32'h0);

    // JTAG pins and TDO synchronizer
    bus_write(32'h14, 32'hF, 4'hF);
    check_eq("jtag_pins", {28'd0, jtag_rst_n, jtag_tdi, jtag_tms, jtag_clk}, 32'hF);
    bus_read(32'h14, rv);
    check_eq("jtag_readback", rv, 32'hF);
    bus_write(32'h14, 32'h6, 4'hF);
    check_eq("jtag_pins2", {28'd0, jtag_rst_n, jtag_tdi, jtag_tms, jtag_clk}, 32'h6);
    jtag_tdo = 1'b1;
    repeat (3) @(posedge clk);
    bus_read(32'h18, rv);
    check_eq("tdo_sync", rv, 32'h1);

    // Unmapped offset and ignored upper address bits
    bus_read(32'h20, rv);
    check_eq("unmapped", rv, 32'h0);
    bus_read(32'hABCD_0100, rv);
    check_eq("addr_alias", rv, 32'hFFFF_5678);

    // rd_data holds across idle cycles and writes
    repeat (3) @(posedge clk);
    bus_write(32'h08, 32'h0, 4'hF);
    #1;
    check_eq("rd_hold", rd_data, 32'hFFFF_5678);

`ifdef TOY_ENV_CYCLE_CNT_EN
    bus_read(32'h1C, c0);
    repeat (9) @(posedge clk);
    bus_read(32'h1C, rv);
    check_eq("cycle_delta", rv - c0, 32'd10);
`else
    bus_read(32'h1C, c0);
    check_eq("cycle_absent", c0, 32'h0);
`endif

    // Asynchronous reset mid-operation
    bus_write(32'h10, 32'd4, 4'hF);
    bus_write(32'h08, 32'h1, 4'hF);
    bus_read(32'h00, rv);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_msip", {31'd0, intr_msip}, 32'h0);
    check_eq("mid_rst_rd", rd_data, 32'h0);
    check_eq("mid_rst_code", finish_code, 32'h0);
    check_eq("mid_rst_jtag", {31'd0, jtag_rst_n}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_rst_no_irq", {31'd0, intr_meip}, 32'h0);
    bus_read(32'h10, rv);
    check_eq("mid_rst_timer", rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
